button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_pkg.sv | 27 ++
 rtl/sync_ff.sv | 24 ++
 rtl/button_debouncer.sv | 140 ++++++++++++++
 tb/tb_button_debouncer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types for the pushbutton debouncer: FSM state encoding and the
// registered output-event bundle.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic long_hold;
  } btn_evt_t;

  localparam btn_evt_t EVT_NONE = '{default: 1'b0};

  // The debounced level is high whenever the button is accepted as pressed,
  // including while a release is still being qualified.
  function automatic logic level_of(input btn_state_e st);
    return (st == HELD) || (st == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop chain bringing an asynchronous level into the clk domain.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  // NOTE: the chain is cleared on reset so no stale press is seen afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: synchronizes the raw level, qualifies press/release by
// stability counting, and emits registered level, edge and long-press events.
module button_debouncer
  import button_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [SW-1:0] STABLE_ONE  = SW'(1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_PRESS_CYCLES - 1);

  logic sync_btn;

  btn_state_e      state_q, state_d;
  logic [SW-1:0]   stable_q, stable_d;
  logic [HW-1:0]   hold_q, hold_d;
  btn_evt_t        evt_q, evt_d;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (btn_raw),
    .q_o  (sync_btn)
  );

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    hold_d   = hold_q;
    evt_d    = EVT_NONE;

    unique case (state_q)
      IDLE: begin
        if (sync_btn) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d     = HELD;
            evt_d.press = 1'b1;
            hold_d      = '0;
            stable_d    = '0;
          end else begin
            state_d  = PRESS_WAIT;
            stable_d = STABLE_ONE;
          end
        end
      end

      PRESS_WAIT: begin
        if (!sync_btn) begin
          state_d  = IDLE;
          stable_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          state_d     = HELD;
          evt_d.press = 1'b1;
          hold_d      = '0;
          stable_d    = '0;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end

      HELD: begin
        if (sync_btn) begin
          // Saturation makes HOLD_LAST reachable only once per press.
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
          if (hold_q == HOLD_LAST) begin
            evt_d.long_hold = 1'b1;
          end
        end else if (DEBOUNCE_CYCLES == 1) begin
          state_d   = IDLE;
          evt_d.rel = 1'b1;
        end else begin
          state_d  = RELEASE_WAIT;
          stable_d = STABLE_ONE;
        end
      end

      RELEASE_WAIT: begin
        if (sync_btn) begin
          state_d  = HELD;
          stable_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          state_d   = IDLE;
          evt_d.rel = 1'b1;
          stable_d  = '0;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        stable_d = '0;
        hold_d   = '0;
      end
    endcase

    evt_d.level = level_of(state_d);
  end

  // NOTE: state registers use non-blocking assignments so all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      stable_q <= '0;
      hold_q   <= '0;
      evt_q    <= EVT_NONE;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      hold_q   <= hold_d;
      evt_q    <= evt_d;
    end
  end

  assign btn_level     = evt_q.level;
  assign press_pulse   = evt_q.press;
  assign release_pulse = evt_q.rel;
  assign long_press    = evt_q.long_hold;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: one instance with DEBOUNCE_CYCLES=4 and
// one with DEBOUNCE_CYCLES=1, checked against hand-computed edge latencies.
module tb_button_debouncer;

  localparam int PRESS_LAT   = 6;   // SYNC_STAGES + DEBOUNCE_CYCLES
  localparam int LONG_LAT    = 16;  // PRESS_LAT + LONG_PRESS_CYCLES
  localparam int PRESS_LAT_B = 3;   // SYNC_STAGES + 1

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_a = 1'b0;
  logic btn_b = 1'b0;

  logic a_level, a_press, a_rel, a_long;
  logic b_level, b_press, b_rel, b_long;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  int a_press_n = 0, a_rel_n = 0, a_long_n = 0;
  int a_press_cyc = -1, a_rel_cyc = -1, a_long_cyc = -1;
  int b_press_n = 0, b_rel_n = 0;
  int overlap_n = 0;

  button_debouncer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10)
  ) dut_a (
    .clk(clk), .reset(reset), .btn_raw(btn_a), .btn_level(a_level),
    .press_pulse(a_press), .release_pulse(a_rel), .long_press(a_long)
  );

  button_debouncer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .LONG_PRESS_CYCLES(10)
  ) dut_b (
    .clk(clk), .reset(reset), .btn_raw(btn_b), .btn_level(b_level),
    .press_pulse(b_press), .release_pulse(b_rel), .long_press(b_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts pulses, remembers the edge index of the latest one.
  always @(negedge clk) begin
    if (a_press) begin a_press_n++; a_press_cyc = cyc; end
    if (a_rel)   begin a_rel_n++;   a_rel_cyc   = cyc; end
    if (a_long)  begin a_long_n++;  a_long_cyc  = cyc; end
    if (b_press) b_press_n++;
    if (b_rel)   b_rel_n++;
    if (int'(a_press) + int'(a_rel) + int'(a_long) > 1) overlap_n++;
    if (int'(b_press) + int'(b_rel) + int'(b_long) > 1) overlap_n++;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int c0, r0, p_snap, r_snap, lvl_and;

  initial begin
    // Reset state
    tick(3);
    check("rst_level",   int'(a_level), 0);
    check("rst_press",   int'(a_press), 0);
    check("rst_release", int'(a_rel),   0);
    check("rst_long",    int'(a_long),  0);
    check("rst_level_b", int'(b_level), 0);
    reset = 1'b0;
    tick(2);

    // Clean press, then long hold, then release
    c0 = cyc;
    btn_a = 1'b1;
    tick(PRESS_LAT - 1);
    check("no_early_press", a_press_n, 0);
    check("level_before",   int'(a_level), 0);
    tick(1);
    check("press_pulse",    int'(a_press), 1);
    check("press_level",    int'(a_level), 1);
    check("press_latency",  a_press_cyc - c0, PRESS_LAT);
    tick(1);
    check("press_one_cyc",  int'(a_press), 0);
    check("level_held",     int'(a_level), 1);
    tick(30 - PRESS_LAT - 1);
    check("long_count",     a_long_n, 1);
    check("long_latency",   a_long_cyc - c0, LONG_LAT);
    r0 = cyc;
    btn_a = 1'b0;
    tick(PRESS_LAT - 1);
    check("no_early_rel",   a_rel_n, 0);
    check("level_rel_wait", int'(a_level), 1);
    tick(1);
    check("release_pulse",  int'(a_rel), 1);
    check("release_level",  int'(a_level), 0);
    check("release_lat",    a_rel_cyc - r0, PRESS_LAT);
    tick(1);
    check("release_one_cyc", int'(a_rel), 0);
    tick(4);

    // Bounce: 3 high, 1 low, then steady high
    p_snap = a_press_n;
    btn_a = 1'b1;
    tick(3);
    btn_a = 1'b0;
    tick(1);
    c0 = cyc;
    btn_a = 1'b1;
    tick(10);
    check("bounce_one_press", a_press_n - p_snap, 1);
    check("bounce_latency",   a_press_cyc - c0, PRESS_LAT);
    btn_a = 1'b0;
    tick(10);
    check("bounce_released",  int'(a_level), 0);

    // Release glitch while held
    btn_a = 1'b1;
    tick(10);
    p_snap = a_press_n;
    r_snap = a_rel_n;
    lvl_and = 1;
    btn_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      lvl_and = lvl_and & int'(a_level);
    end
    btn_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      lvl_and = lvl_and & int'(a_level);
    end
    check("glitch_no_release", a_rel_n - r_snap, 0);
    check("glitch_no_press",   a_press_n - p_snap, 0);
    check("glitch_level",      lvl_and, 1);

    // Reset while held, button still down afterwards
    r_snap = a_rel_n;
    reset = 1'b1;
    tick(1);
    check("midrst_level",   int'(a_level), 0);
    check("midrst_press",   int'(a_press), 0);
    check("midrst_release", int'(a_rel),   0);
    check("midrst_long",    int'(a_long),  0);
    reset = 1'b0;
    c0 = cyc;
    p_snap = a_press_n;
    tick(PRESS_LAT + 4);
    check("midrst_repress",  a_press_n - p_snap, 1);
    check("midrst_latency",  a_press_cyc - c0, PRESS_LAT);
    check("midrst_no_rel",   a_rel_n - r_snap, 0);
    btn_a = 1'b0;
    tick(10);

    // DEBOUNCE_CYCLES = 1 instance
    btn_b = 1'b1;
    tick(PRESS_LAT_B - 1);
    check("b_no_early", b_press_n, 0);
    tick(1);
    check("b_press",    int'(b_press), 1);
    check("b_level",    int'(b_level), 1);
    tick(1);
    check("b_press_one", int'(b_press), 0);
    btn_b = 1'b0;
    tick(PRESS_LAT_B - 1);
    check("b_no_early_rel", b_rel_n, 0);
    tick(1);
    check("b_release",  int'(b_rel), 1);
    check("b_rel_level", int'(b_level), 0);
    tick(3);

    check("pulse_overlap", overlap_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
